vga_timing_gen: RTL and testbench

- Parametrised raster timing generator: successor to the fixed 640x480 text counters.
- Produces a pixel clock-enable, horizontal and vertical position counters with full porch/sync timing, sync pulses with configurable polarity, an active-video flag, character-cell coordinates and line/frame start strobes.
- Sits between the system clock domain and the text renderer / glyph ROM lookup, which consume position and cell coordinates every `pix_ce`.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/wrap_counter.sv | 20 ++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants and decode helpers
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} sync_region_e;
  function automatic int h_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction
  function automatic int v_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction
  // Never returns a zero width, so degenerate configs still get a 1-bit port.
  function automatic int width_of(int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  function automatic sync_region_e region_of(int pos, int act, int fp, int sync);
    return pos < act ? ACTIVE : pos < act + fp ? FRONT : pos < act + fp + sync ? SYNC : BACK;
  endfunction
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo counter with terminal-value load, exposing its next value
module wrap_counter #(
  parameter int W = 4,
  parameter int LAST = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         load,
  output logic [W-1:0] q,
  output logic [W-1:0] nxt,
  output logic         wrap
);
  assign wrap = inc && !load && q == W'(LAST);
  assign nxt = load ? W'(LAST) : !inc ? q : wrap ? '0 : q + 1'b1;
  // Position register; reset parks it on the terminal value so the first increment yields 0.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= W'(LAST);
    else q <= nxt;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with cell coordinates
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 16,
  parameter int PIX_DIV = 2,
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW = width_of(H_TOTAL),
  localparam int VW = width_of(V_TOTAL),
  localparam int XCW = width_of(H_ACTIVE / CHAR_W),
  localparam int YCW = width_of(V_ACTIVE / CHAR_H),
  localparam int XDW = width_of(CHAR_W),
  localparam int YDW = width_of(CHAR_H)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           restart,
  output logic           pix_ce,
  output logic [HW-1:0]  dot_counter,
  output logic [VW-1:0]  scanline_counter,
  output logic           hsync,
  output logic           vsync,
  output logic           active,
  output logic [XCW-1:0] x_char,
  output logic [YCW-1:0] y_char,
  output logic [XDW-1:0] x_dot,
  output logic [YDW-1:0] y_dot,
  output logic           line_start,
  output logic           frame_start
);
  localparam int PW = width_of(PIX_DIV);
  localparam int XS = $clog2(CHAR_W);
  localparam int YS = $clog2(CHAR_H);
  logic [PW-1:0] presc;
  logic          term;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;
  logic          h_wrap;
  logic          v_wrap;
  logic          act_d;
  sync_region_e  h_reg;
  sync_region_e  v_reg;
  assign term = presc == PW'(PIX_DIV - 1);
  // Prescaler: holds while en is low, restart re-aligns it with the parked position.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc <= '0;
      pix_ce <= 1'b0;
    end else if (restart) begin
      presc <= '0;
      pix_ce <= 1'b0;
    end else if (en) begin
      presc <= term ? '0 : presc + 1'b1;
      pix_ce <= term;
    end else begin
      pix_ce <= 1'b0;
    end
  wrap_counter #(.W(HW), .LAST(H_TOTAL - 1)) u_h (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (pix_ce),
    .load (restart),
    .q    (dot_counter),
    .nxt  (h_nxt),
    .wrap (h_wrap)
  );
  wrap_counter #(.W(VW), .LAST(V_TOTAL - 1)) u_v (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (h_wrap),
    .load (restart),
    .q    (scanline_counter),
    .nxt  (v_nxt),
    .wrap (v_wrap)
  );
  assign h_reg = region_of(int'(h_nxt), H_ACTIVE, H_FP, H_SYNC);
  assign v_reg = region_of(int'(v_nxt), V_ACTIVE, V_FP, V_SYNC);
  assign act_d = h_reg == ACTIVE && v_reg == ACTIVE;
  // Decode from the counters' next values so outputs land on the same edge as the position.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      active <= 1'b0;
      hsync <= !HS_POL;
      vsync <= !VS_POL;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      x_char <= '0;
      y_char <= '0;
      x_dot <= '0;
      y_dot <= '0;
    end else begin
      active <= act_d;
      hsync <= h_reg == SYNC ? HS_POL : !HS_POL;
      vsync <= v_reg == SYNC ? VS_POL : !VS_POL;
      line_start <= h_wrap;
      frame_start <= v_wrap;
      x_char <= act_d ? XCW'(h_nxt >> XS) : '0;
      y_char <= act_d ? YCW'(v_nxt >> YS) : '0;
      x_dot <= act_d ? XDW'(h_nxt & HW'(CHAR_W - 1)) : '0;
      y_dot <= act_d ? YDW'(v_nxt & VW'(CHAR_H - 1)) : '0;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on default, tall-narrow and tiny raster configurations
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0, rst_m = 1'b0, rst_s = 1'b0;
  logic en = 1'b0, restart = 1'b0, restart_m = 1'b0, restart_s = 1'b0;
  int cyc = 0;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       pix_ce, hsync, vsync, active, ls, fs;
  logic [9:0] dot, line;
  logic [6:0] xc;
  logic [4:0] yc;
  logic [2:0] xd;
  logic [3:0] yd;
  vga_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .pix_ce(pix_ce),
    .dot_counter(dot), .scanline_counter(line), .hsync(hsync), .vsync(vsync),
    .active(active), .x_char(xc), .y_char(yc), .x_dot(xd), .y_dot(yd),
    .line_start(ls), .frame_start(fs)
  );

  logic       pix_ce_m, hsync_m, vsync_m, active_m, ls_m, fs_m;
  logic [2:0] dot_m;
  logic [9:0] line_m;
  logic [0:0] xc_m;
  logic [4:0] yc_m;
  logic [2:0] xd_m;
  logic [3:0] yd_m;
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .PIX_DIV(1)) dut_m (
    .clk(clk), .rst_n(rst_m), .en(en), .restart(restart_m), .pix_ce(pix_ce_m),
    .dot_counter(dot_m), .scanline_counter(line_m), .hsync(hsync_m), .vsync(vsync_m),
    .active(active_m), .x_char(xc_m), .y_char(yc_m), .x_dot(xd_m), .y_dot(yd_m),
    .line_start(ls_m), .frame_start(fs_m)
  );

  logic       pix_ce_s, hsync_s, vsync_s, active_s, ls_s, fs_s;
  logic [2:0] dot_s, line_s;
  logic [0:0] xc_s, yc_s;
  logic [2:0] xd_s;
  logic [3:0] yd_s;
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .PIX_DIV(1), .HS_POL(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_s), .en(en), .restart(restart_s), .pix_ce(pix_ce_s),
    .dot_counter(dot_s), .scanline_counter(line_s), .hsync(hsync_s), .vsync(vsync_s),
    .active(active_s), .x_char(xc_s), .y_char(yc_s), .x_dot(xd_s), .y_dot(yd_s),
    .line_start(ls_s), .frame_start(fs_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int cur_h(input int sel);
    return sel == 0 ? int'(dot) : int'(dot_m);
  endfunction

  function automatic int cur_v(input int sel);
    return sel == 0 ? int'(line) : int'(line_m);
  endfunction

  // Steps until the chosen instance first shows (h,v); an expired budget is a failure.
  task automatic wait_pos(input int sel, input int h, input int v, input int limit);
    int n = 0;
    while (!(cur_h(sel) == h && cur_v(sel) == v) && n < limit) begin
      step(1);
      n++;
    end
    chk($sformatf("reach_%0d_%0d_%0d", sel, h, v), 32'(n < limit), 1);
  endtask

  int t0, tf, n;
  int mh, mv;
  logic mce, mls, mfs, act, hs, vs;
  logic [31:0] exp_v, obs_v;

  initial begin
    step(2);
    chk("rst_dot", 32'(dot), 799);
    chk("rst_line", 32'(line), 524);
    chk("rst_pix_ce", 32'(pix_ce), 0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_active", 32'(active), 0);
    chk("rst_fs", 32'(fs), 0);

    en = 1'b1;
    rst_m = 1'b1;
    wait_pos(1, 0, 0, 10);
    chk("m_first_fs", 32'(fs_m), 1);
    tf = cyc;
    wait_pos(1, 7, 489, 5000);
    chk("m_vs_489", 32'(vsync_m), 1);
    wait_pos(1, 0, 490, 100);
    chk("m_vs_490", 32'(vsync_m), 0);
    wait_pos(1, 7, 491, 100);
    chk("m_vs_491", 32'(vsync_m), 0);
    wait_pos(1, 0, 492, 100);
    chk("m_vs_492", 32'(vsync_m), 1);
    wait_pos(1, 0, 0, 5000);
    chk("m_fs_again", 32'(fs_m), 1);
    chk("m_frame_period", 32'(cyc - tf), 4200);
    rst_m = 1'b0;

    rst_n = 1'b1;
    step(1);
    chk("ce_first_clk", 32'(pix_ce), 0);
    step(1);
    chk("ce_second_clk", 32'(pix_ce), 1);
    chk("dot_before_first", 32'(dot), 799);
    step(1);
    chk("first_dot", 32'(dot), 0);
    chk("first_line", 32'(line), 0);
    chk("first_fs", 32'(fs), 1);
    chk("first_ls", 32'(ls), 1);
    chk("first_active", 32'(active), 1);
    chk("first_ce_low", 32'(pix_ce), 0);
    t0 = cyc;
    step(1);
    chk("fs_one_clk", 32'(fs), 0);
    chk("ls_one_clk", 32'(ls), 0);
    chk("ce_again", 32'(pix_ce), 1);

    wait_pos(0, 639, 0, 2000);
    chk("act_639", 32'(active), 1);
    wait_pos(0, 640, 0, 10);
    chk("act_640", 32'(active), 0);
    wait_pos(0, 655, 0, 100);
    chk("hs_655", 32'(hsync), 1);
    wait_pos(0, 656, 0, 10);
    chk("hs_656", 32'(hsync), 0);
    wait_pos(0, 751, 0, 400);
    chk("hs_751", 32'(hsync), 0);
    wait_pos(0, 752, 0, 10);
    chk("hs_752", 32'(hsync), 1);
    wait_pos(0, 0, 1, 400);
    chk("ls_line1", 32'(ls), 1);
    chk("fs_line1", 32'(fs), 0);
    chk("line_period", 32'(cyc - t0), 1600);

    wait_pos(0, 17, 35, 60000);
    chk("x_char_17", 32'(xc), 2);
    chk("x_dot_17", 32'(xd), 1);
    chk("y_char_35", 32'(yc), 2);
    chk("y_dot_35", 32'(yd), 3);
    wait_pos(0, 645, 35, 2000);
    chk("cells_645", 32'({xc, yc, xd, yd}), 0);

    wait_pos(0, 300, 36, 2000);
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("hold_ce", 32'(pix_ce), 0);
      chk("hold_dot", 32'(dot), 300);
    end
    en = 1'b1;
    step(1);
    chk("resume_ce", 32'(pix_ce), 1);
    chk("resume_dot_held", 32'(dot), 300);
    step(1);
    chk("resume_dot", 32'(dot), 301);

    n = 0;
    while (pix_ce !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    chk("restart_ce_seen", 32'(pix_ce), 1);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("restart_dot", 32'(dot), 799);
    chk("restart_line", 32'(line), 524);
    chk("restart_ce", 32'(pix_ce), 0);
    chk("restart_active", 32'(active), 0);
    step(1);
    chk("restart_ce1", 32'(pix_ce), 0);
    step(1);
    chk("restart_ce2", 32'(pix_ce), 1);
    step(1);
    chk("restart_wrap", 32'({dot, line}), 0);
    chk("restart_fs", 32'(fs), 1);
    chk("restart_ls", 32'(ls), 1);

    step(5);
    rst_n = 1'b0;
    #1;
    chk("async_dot", 32'(dot), 799);
    chk("async_line", 32'(line), 524);
    chk("async_active", 32'(active), 0);
    chk("async_x_dot", 32'(xd), 0);
    chk("async_hsync", 32'(hsync), 1);

    mh = 7; mv = 5; mce = 1'b0; mls = 1'b0; mfs = 1'b0;
    rst_s = 1'b1;
    for (int i = 0; i < 150; i++) begin
      en = (i % 11) != 4;
      restart_s = i == 40 || i == 41 || i == 90;
      @(posedge clk);
      if (restart_s) begin
        mh = 7; mv = 5; mce = 1'b0; mls = 1'b0; mfs = 1'b0;
      end else begin
        mls = mce && mh == 7;
        mfs = mls && mv == 5;
        if (mce) begin
          mh = mh == 7 ? 0 : mh + 1;
          if (mls) mv = mv == 5 ? 0 : mv + 1;
        end
        mce = en;
      end
      #1;
      act = mh < 4 && mv < 3;
      hs = mh == 5 || mh == 6;
      vs = mv != 4;
      exp_v = 32'({mce, 3'(mh), 3'(mv), hs, vs, act, mls, mfs, 1'b0, 1'b0,
                   act ? 3'(mh) : 3'd0, act ? 4'(mv) : 4'd0});
      obs_v = 32'({pix_ce_s, dot_s, line_s, hsync_s, vsync_s, active_s, ls_s, fs_s,
                   xc_s, yc_s, xd_s, yd_s});
      chk($sformatf("small_cfg_%0d", i), obs_v, exp_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
